// File: rtl/fifo_rd_stream.sv
// Drain stage behind fifo_syn: issues reads, absorbs the 1-cycle read latency and
// re-times the words into a valid/ready stream with a per-burst m_last marker.
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 4,
  parameter int SKID_DEPTH = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          fifo_empty,
  input  logic [DATA_WIDTH-1:0]         fifo_data,
  output logic                          fifo_cs,
  output logic                          fifo_rd_en,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [DATA_WIDTH-1:0]         m_data,
  output logic                          m_last,
  output logic                          busy,
  output logic [1:0]                    state_dbg,
  output logic [1:0]                    occ_dbg,
  output logic [$clog2(BURST_LEN):0]    beat_cnt_dbg
);

  localparam int BW = $clog2(BURST_LEN) + 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);
  localparam logic [2:0]    DEPTH     = 3'(SKID_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                state, state_next;
  logic [DATA_WIDTH-1:0] mem [0:2];
  logic [1:0]            wr_ptr, rd_ptr;
  logic [1:0]            occ;
  logic                  inflight;
  logic [BW-1:0]         beat_cnt;
  logic [2:0]            held;
  logic                  push, pop;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Stream handshake: a beat transfers on every rising edge where m_valid && m_ready;
  // m_valid never waits for m_ready, and m_data/m_last hold while m_valid && !m_ready.
  // The read request only looks at registered occupancy, never at m_ready.
  assign held       = {1'b0, occ} + {2'b00, inflight};
  assign fifo_rd_en = !rst && en && !fifo_empty && (held < DEPTH);
  assign fifo_cs    = fifo_rd_en;

  assign push    = inflight;
  assign m_valid = (occ != 2'd0);
  assign pop     = m_valid && m_ready;
  assign m_data  = mem[rd_ptr];
  assign m_last  = m_valid && (beat_cnt == LAST_BEAT);
  assign busy    = (state != IDLE);

  assign state_dbg    = state;
  assign occ_dbg      = occ;
  assign beat_cnt_dbg = beat_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      occ      <= 2'd0;
      inflight <= 1'b0;
      wr_ptr   <= 2'd0;
      rd_ptr   <= 2'd0;
      beat_cnt <= '0;
      for (int i = 0; i < 3; i++) mem[i] <= '0;
    end else begin
      inflight <= fifo_rd_en;
      if (push) begin
        mem[wr_ptr] <= fifo_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr   <= ptr_inc(rd_ptr);
        beat_cnt <= m_last ? '0 : beat_cnt + BW'(1);
      end
      if (push && !pop)      occ <= occ + 2'd1;
      else if (!push && pop) occ <= occ - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Leaving RUN with words still owed goes through DRAIN so they are delivered.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (en) state_next = RUN;
      RUN:     if (!en) state_next = (held != 3'd0) ? DRAIN : IDLE;
      DRAIN: begin
        if (en)                 state_next = RUN;
        else if (held == 3'd0)  state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst && push) assert (occ != 2'd3);
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a behavioural fifo_syn model and a data scoreboard.
module tb_fifo_rd_stream;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst, en, fifo_empty, m_ready;
  logic [DW-1:0] fifo_data;
  logic          fifo_cs, fifo_rd_en, m_valid, m_last, busy;
  logic [DW-1:0] m_data;
  logic [1:0]    state_dbg, occ_dbg;
  logic [2:0]    beat_cnt_dbg;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] fq[$];
  logic [DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  fifo_rd_stream #(.DATA_WIDTH(DW), .BURST_LEN(4), .SKID_DEPTH(3)) dut (
    .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_cs(fifo_cs), .fifo_rd_en(fifo_rd_en), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last), .busy(busy), .state_dbg(state_dbg),
    .occ_dbg(occ_dbg), .beat_cnt_dbg(beat_cnt_dbg)
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fifo_push(input logic [DW-1:0] w);
    fq.push_back(w);
    exp_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  // One clock: sample handshakes before the edge, then update the FIFO model after it.
  task automatic tick();
    logic          rd, popd, ne;
    logic [DW-1:0] d, e;
    #1;
    rd   = fifo_rd_en;
    popd = m_valid && m_ready && !rst;
    d    = m_data;
    @(posedge clk);
    #1;
    if (rd) begin
      ne = (fq.size() != 0);
      check("read_from_nonempty_fifo", ne, 1);
      if (ne) fifo_data = fq.pop_front();
    end
    if (popd) begin
      if (exp_q.size() != 0) e = exp_q.pop_front();
      else e = 'x;
      check("sb_data", d, e);
    end
    fifo_empty = (fq.size() == 0);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; m_ready = 1'b0; fifo_empty = 1'b1; fifo_data = '0;

    // Reset
    tick();
    check("rst_m_valid", m_valid, 0);
    check("rst_rd_en", fifo_rd_en, 0);
    check("rst_busy", busy, 0);
    check("rst_m_last", m_last, 0);
    check("rst_m_data", m_data, 0);
    check("rst_state", state_dbg, 0);
    tick();
    rst = 1'b0;

    // Continuous stream of 8 words
    for (int i = 1; i <= 8; i++) fifo_push(i);
    en = 1'b1; m_ready = 1'b1;
    #1;
    check("t2_first_rd_en", fifo_rd_en, 1);
    check("t2_first_cs", fifo_cs, 1);
    check("t2_idle_valid", m_valid, 0);
    tick();
    check("t2_lat1_valid", m_valid, 0);
    check("t2_busy", busy, 1);
    tick();
    check("t2_lat2_valid", m_valid, 1);
    check("t2_data", m_data, 1);
    check("t2_last", m_last, 0);
    for (int k = 2; k <= 8; k++) begin
      tick();
      check("t2_valid", m_valid, 1);
      check("t2_data", m_data, k);
      check("t2_last", m_last, (k == 4 || k == 8) ? 1 : 0);
    end
    tick();
    check("t2_end_valid", m_valid, 0);
    check("t2_end_beat", beat_cnt_dbg, 0);

    // Backpressure
    for (int i = 9; i <= 16; i++) fifo_push(i);
    tick();
    tick();
    check("t3_data9", m_data, 9);
    tick();
    check("t3_data10", m_data, 10);
    m_ready = 1'b0;
    for (int s = 0; s < 6; s++) begin
      tick();
      check("t3_stall_valid", m_valid, 1);
      check("t3_stall_data", m_data, 10);
      check("t3_stall_last", m_last, 0);
      check("t3_stall_rd_en", fifo_rd_en, 0);
    end
    check("t3_occ_full", occ_dbg, 3);
    m_ready = 1'b1;
    #1;
    check("t3_release_rd_en", fifo_rd_en, 0);
    for (int k = 10; k <= 16; k++) begin
      check("t3_valid", m_valid, 1);
      check("t3_data", m_data, k);
      check("t3_last", m_last, (k == 12 || k == 16) ? 1 : 0);
      tick();
    end
    check("t3_end_valid", m_valid, 0);

    // FIFO runs empty mid-burst
    fifo_push(32'h21); fifo_push(32'h22);
    tick();
    tick();
    check("t4_data21", m_data, 32'h21);
    check("t4_last21", m_last, 0);
    tick();
    check("t4_data22", m_data, 32'h22);
    tick();
    check("t4_gap_valid_a", m_valid, 0);
    tick();
    check("t4_gap_valid_b", m_valid, 0);
    fifo_push(32'h23); fifo_push(32'h24); fifo_push(32'h25);
    tick();
    check("t4_gap_valid_c", m_valid, 0);
    tick();
    check("t4_data23", m_data, 32'h23);
    check("t4_last23", m_last, 0);
    tick();
    check("t4_data24", m_data, 32'h24);
    check("t4_last24", m_last, 1);
    tick();
    check("t4_data25", m_data, 32'h25);
    check("t4_last25", m_last, 0);
    tick();
    check("t4_end_valid", m_valid, 0);
    check("t4_end_beat", beat_cnt_dbg, 1);

    // en drop with two buffered and one in flight
    m_ready = 1'b0;
    for (int i = 32'h31; i <= 32'h35; i++) fifo_push(i);
    tick(); tick(); tick();
    check("t5_occ", occ_dbg, 2);
    check("t5_state_run", state_dbg, 1);
    en = 1'b0; m_ready = 1'b1;
    #1;
    check("t5_no_rd_en", fifo_rd_en, 0);
    check("t5_data31", m_data, 32'h31);
    check("t5_last31", m_last, 0);
    tick();
    check("t5_state_drain", state_dbg, 2);
    check("t5_busy_drain", busy, 1);
    check("t5_data32", m_data, 32'h32);
    tick();
    check("t5_data33", m_data, 32'h33);
    check("t5_last33", m_last, 1);
    tick();
    check("t5_drained_valid", m_valid, 0);
    check("t5_state_drain_end", state_dbg, 2);
    tick();
    check("t5_state_idle", state_dbg, 0);
    check("t5_busy_idle", busy, 0);
    check("t5_idle_rd_en", fifo_rd_en, 0);
    tick();
    check("t5_idle_rd_en_b", fifo_rd_en, 0);
    check("t5_idle_valid", m_valid, 0);

    // Reset in the middle of a burst
    for (int i = 32'h36; i <= 32'h39; i++) fifo_push(i);
    en = 1'b1;
    tick();
    tick();
    check("t6_data34", m_data, 32'h34);
    tick();
    check("t6_data35", m_data, 32'h35);
    tick();
    check("t6_data36", m_data, 32'h36);
    check("t6_beat2", beat_cnt_dbg, 2);
    m_ready = 1'b0;
    tick();
    check("t6_pre_occ", occ_dbg, 2);
    check("t6_pre_beat", beat_cnt_dbg, 2);
    rst = 1'b1;
    #1;
    check("t6_rst_rd_en", fifo_rd_en, 0);
    tick();
    check("t6_rst_valid", m_valid, 0);
    check("t6_rst_beat", beat_cnt_dbg, 0);
    check("t6_rst_occ", occ_dbg, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_last", m_last, 0);
    repeat (3) void'(exp_q.pop_front());
    rst = 1'b0; m_ready = 1'b1;
    tick();
    check("t6_lat_valid", m_valid, 0);
    tick();
    check("t6_valid39", m_valid, 1);
    check("t6_data39", m_data, 32'h39);
    check("t6_last39", m_last, 0);
    tick();
    check("t6_end_valid", m_valid, 0);
    check("t6_end_beat", beat_cnt_dbg, 1);
    check("sb_all_delivered", exp_q.size(), 0);
    check("fifo_model_empty", fq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
